sc_charge_scheduler: RTL

- Shares limited grid capacity among NUM_PORTS charger ports.
- Each port's charge FSM raises a request. This block issues per-port charge grants, capped by a concurrency limit derived from grid_state.
- Grants rotate between ports round-robin on a fixed time slice.
- On a critical grid, all grants are shed; they are re-admitted only after a stable-grid recovery window.

---
 rtl/sc_charge_scheduler_pkg.sv | 10 +
 rtl/sc_charge_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sc_charge_scheduler_pkg.sv
// Shared types for the charge scheduler: the classified grid condition it consumes.
package sc_charge_scheduler_pkg;

    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2
    } grid_state_t;

endpackage

// File: rtl/sc_charge_scheduler.sv
// Round-robin grant scheduler sharing grid capacity among charger ports,
// with load shedding on a critical grid and a stable-grid recovery window.
//
// state   | meaning
// RUN     | grants admitted/rotated under the grid-derived limit
// SHED    | grid critical, all grants held off
// RECOVER | counting consecutive non-critical cycles before re-admitting
module sc_charge_scheduler
    import sc_charge_scheduler_pkg::*;
#(
    parameter int NUM_PORTS           = 4,
    parameter int MAX_ACTIVE_NORMAL   = 2,
    parameter int MAX_ACTIVE_UNSTABLE = 1,
    parameter int SLICE_CYCLES        = 1000,
    parameter int RECOVERY_CYCLES     = 256
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  grid_state_t                    grid_state,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS-1:0]           port_fault,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [$clog2(NUM_PORTS+1)-1:0] active_count,
    output logic [1:0]                     sched_state,
    output logic                           slice_pulse
);

    localparam int CW = $clog2(NUM_PORTS + 1);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = $clog2(SLICE_CYCLES);
    localparam int RW = $clog2(RECOVERY_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SHED    = 2'd1,
        ST_RECOVER = 2'd2
    } sched_t;

    sched_t         state_q;
    logic [RW-1:0]  rec_cnt_q;
    logic [SW-1:0]  slice_cnt_q;
    logic [PW-1:0]  rr_q;

    logic [NUM_PORTS-1:0] kept;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [CW-1:0]        kept_cnt;
    logic [CW-1:0]        limit;
    logic [PW-1:0]        top_idx;
    logic [PW-1:0]        revoke_idx;
    logic [PW-1:0]        admit_idx;
    logic [PW-1:0]        rr_nxt;
    logic                 critical;
    logic                 slice_cond;
    logic                 slice_fire;

    function automatic logic [CW-1:0] popcount(input logic [NUM_PORTS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // First set bit of vec scanning upward from start, wrapping past the top port.
    function automatic logic [PW-1:0] first_from(input logic [NUM_PORTS-1:0] vec,
                                                 input logic [PW-1:0]        start);
        logic [PW-1:0] sel;
        logic [PW-1:0] p;
        logic          hit;
        int            idx;
        sel = start;
        hit = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            p = PW'(idx);
            if (!hit && vec[p]) begin
                sel = p;
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        critical = (grid_state == GRID_CRITICAL);
        kept     = grant & req & ~port_fault;
        eligible = req & ~port_fault & ~grant;
        kept_cnt = popcount(kept);

        limit = '0;
        if (state_q == ST_RUN) begin
            if (grid_state == GRID_NORMAL)   limit = CW'(MAX_ACTIVE_NORMAL);
            if (grid_state == GRID_UNSTABLE) limit = CW'(MAX_ACTIVE_UNSTABLE);
        end

        top_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (kept[i]) top_idx = PW'(i);
        end
        revoke_idx = first_from(kept, rr_q);
        admit_idx  = first_from(eligible, rr_q);

        slice_cond = (limit != '0) && (kept_cnt == limit) && (|eligible);
        slice_fire = slice_cond && (slice_cnt_q == SW'(SLICE_CYCLES - 1));

        grant_nxt = '0;
        rr_nxt    = rr_q;
        if (state_q == ST_RUN && !critical) begin
            grant_nxt = kept;
            if (kept_cnt > limit) begin
                grant_nxt[top_idx] = 1'b0;
            end else if (slice_fire) begin
                grant_nxt[revoke_idx] = 1'b0;
                rr_nxt = wrap_inc(revoke_idx);
            end else if (kept_cnt < limit && (|eligible)) begin
                grant_nxt[admit_idx] = 1'b1;
                rr_nxt = wrap_inc(admit_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RECOVER;
            rec_cnt_q    <= '0;
            slice_cnt_q  <= '0;
            rr_q         <= '0;
            grant        <= '0;
            active_count <= '0;
            slice_pulse  <= 1'b0;
        end else begin
            grant        <= grant_nxt;
            active_count <= popcount(grant_nxt);
            slice_pulse  <= slice_fire;
            rr_q         <= rr_nxt;
            slice_cnt_q  <= (slice_cond && !slice_fire) ? slice_cnt_q + 1'b1 : '0;

            case (state_q)
                ST_RUN: begin
                    if (critical) state_q <= ST_SHED;
                end
                ST_SHED: begin
                    if (!critical) begin
                        state_q   <= ST_RECOVER;
                        rec_cnt_q <= '0;
                    end
                end
                ST_RECOVER: begin
                    if (critical) begin
                        state_q   <= ST_SHED;
                        rec_cnt_q <= '0;
                    end else if (rec_cnt_q == RW'(RECOVERY_CYCLES - 1)) begin
                        state_q   <= ST_RUN;
                        rec_cnt_q <= '0;
                    end else begin
                        rec_cnt_q <= rec_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_RECOVER;
                    rec_cnt_q <= '0;
                end
            endcase
        end
    end

    assign sched_state = state_q;

endmodule
